n_counter_cfg_ctrl: RTL and testbench

Disciplines the fractional clock divider against the GPS 1PPS.
- Measures clk_in cycles between consecutive PPS rising edges (M).
- Computes Q = floor(M·2^12 / F_OUT) with a sequential restoring divider.
- Drives the divider's 32-bit integer setting n and its 12-bit sigma-delta remainder rem, so the divider output tracks F_OUT Hz as the oscillator drifts.
- Reports lock, PPS loss and measurement rejection.

---
 rtl/n_counter_cfg_ctrl.sv | 164 ++++++++++++++++
 tb/tb_n_counter_cfg_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/n_counter_cfg_ctrl.sv
// Disciplines the fractional clock divider against GPS 1PPS: it measures clk_in cycles
// per second and derives n/rem = floor(M*2^12/F_OUT) with a restoring divider.
module n_counter_cfg_ctrl #(
  parameter logic [31:0] F_OUT       = 32'd1000,
  parameter logic [31:0] N_DEFAULT   = 32'd100000,
  parameter logic [31:0] MIN_COUNT   = 32'd90000000,
  parameter logic [31:0] MAX_COUNT   = 32'd110000000,
  parameter logic [31:0] PPS_TIMEOUT = 32'd150000000,
  parameter logic [31:0] LOCK_COUNT  = 32'd3
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        pps_in,
  output logic [31:0] n_out,
  output logic [11:0] rem_out,
  output logic        cfg_update,
  output logic        cfg_valid,
  output logic        locked,
  output logic        pps_missing,
  output logic        meas_reject,
  output logic [31:0] measure_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEASURE,
    S_CHECK,
    S_DIVIDE,
    S_UPDATE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync2_d;
  logic        w_pps_rise;

  logic [31:0] r_cnt;
  logic [31:0] w_meas;
  logic        r_seen;
  logic        w_timeout;
  logic        w_in_range;

  logic [43:0] r_dvd;
  logic [42:0] r_quo;
  logic [32:0] r_rem;
  logic [33:0] w_trial;
  logic [32:0] w_diff;
  logic        w_qbit;
  logic [5:0]  r_bit;
  logic        w_last_bit;
  logic [31:0] r_good;

  assign w_pps_rise = r_sync2 & ~r_sync2_d;
  assign w_meas     = (r_cnt == '1) ? r_cnt : r_cnt + 32'd1;
  assign w_in_range = (measure_count >= MIN_COUNT) && (measure_count <= MAX_COUNT);

  // Flag is raised on the same edge cnt reaches PPS_TIMEOUT; a coincident edge wins.
  assign w_timeout  = r_seen && (r_cnt == PPS_TIMEOUT - 32'd1) && !w_pps_rise &&
                      ((r_state == S_IDLE) || (r_state == S_MEASURE));

  assign w_trial    = {r_rem, r_dvd[43]};
  assign w_qbit     = (w_trial >= {2'b00, F_OUT});
  assign w_diff     = w_trial[32:0] - {1'b0, F_OUT};
  assign w_last_bit = (r_bit == 6'd43);

  always_ff @(posedge clk_in) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_pps_rise) w_next = S_MEASURE;
      S_MEASURE: begin
        if (w_pps_rise)     w_next = S_CHECK;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_CHECK:   w_next = w_in_range ? S_DIVIDE : S_MEASURE;
      S_DIVIDE:  if (w_last_bit) w_next = S_UPDATE;
      S_UPDATE:  w_next = S_MEASURE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_update  = 1'b0;
    meas_reject = 1'b0;
    if (r_state == S_UPDATE)               cfg_update  = 1'b1;
    if (r_state == S_CHECK && !w_in_range) meas_reject = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_sync2_d     <= 1'b0;
      r_cnt         <= '0;
      r_seen        <= 1'b0;
      pps_missing   <= 1'b0;
      measure_count <= '0;
      n_out         <= N_DEFAULT;
      rem_out       <= '0;
      cfg_valid     <= 1'b0;
      locked        <= 1'b0;
      r_good        <= '0;
      r_dvd         <= '0;
      r_quo         <= '0;
      r_rem         <= '0;
      r_bit         <= '0;
    end else begin
      r_sync1   <= pps_in;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;

      if (w_pps_rise)         r_cnt <= '0;
      else if (r_cnt != '1)   r_cnt <= r_cnt + 32'd1;

      if (w_pps_rise) begin
        r_seen      <= 1'b1;
        pps_missing <= 1'b0;
      end else if (w_timeout) begin
        pps_missing <= 1'b1;
      end

      case (r_state)
        S_MEASURE: if (w_pps_rise) measure_count <= w_meas;
        S_CHECK: begin
          r_dvd <= {measure_count, 12'h000};
          r_rem <= '0;
          r_quo <= '0;
          r_bit <= '0;
          if (!w_in_range) begin
            locked <= 1'b0;
            r_good <= '0;
          end
        end
        S_DIVIDE: begin
          r_dvd <= {r_dvd[42:0], 1'b0};
          r_rem <= w_qbit ? w_diff : w_trial[32:0];
          r_quo <= {r_quo[41:0], w_qbit};
          r_bit <= r_bit + 6'd1;
          // Results land on the edge into UPDATE so they coincide with cfg_update.
          if (w_last_bit) begin
            {n_out, rem_out} <= {r_quo, w_qbit};
            cfg_valid        <= 1'b1;
            if (r_good < LOCK_COUNT)            r_good <= r_good + 32'd1;
            if (r_good + 32'd1 >= LOCK_COUNT)   locked <= 1'b1;
          end
        end
        default: ;
      endcase

      if (w_timeout) begin
        locked <= 1'b0;
        r_good <= '0;
      end
    end
  end

endmodule

// File: tb/tb_n_counter_cfg_ctrl.sv
// Scoreboard bench for n_counter_cfg_ctrl: a reference model predicts each update or
// rejection when a PPS pulse is driven; a negedge monitor pops and compares them.
module tb_n_counter_cfg_ctrl;

  localparam logic [31:0] F_OUT_P   = 32'd10;
  localparam logic [31:0] N_DEF_P   = 32'd7;
  localparam logic [31:0] MIN_P     = 32'd500;
  localparam logic [31:0] MAX_P     = 32'd2000;
  localparam logic [31:0] TMO_P     = 32'd5000;
  localparam logic [31:0] LOCK_P    = 32'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pps_in = 1'b0;
  logic [31:0] n_out;
  logic [11:0] rem_out;
  logic        cfg_update;
  logic        cfg_valid;
  logic        locked;
  logic        pps_missing;
  logic        meas_reject;
  logic [31:0] measure_count;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  typedef struct {
    logic [31:0] n;
    logic [11:0] rem;
    int unsigned at;
    logic        lck;
  } upd_t;

  typedef struct {
    logic [31:0] m;
    int unsigned at;
  } rej_t;

  upd_t upd_q[$];
  rej_t rej_q[$];

  logic        m_meas = 1'b0;
  int unsigned m_last = 0;
  int unsigned m_good = 0;

  n_counter_cfg_ctrl #(
    .F_OUT       (F_OUT_P),
    .N_DEFAULT   (N_DEF_P),
    .MIN_COUNT   (MIN_P),
    .MAX_COUNT   (MAX_P),
    .PPS_TIMEOUT (TMO_P),
    .LOCK_COUNT  (LOCK_P)
  ) u_dut (
    .clk_in        (clk),
    .reset         (reset),
    .pps_in        (pps_in),
    .n_out         (n_out),
    .rem_out       (rem_out),
    .cfg_update    (cfg_update),
    .cfg_valid     (cfg_valid),
    .locked        (locked),
    .pps_missing   (pps_missing),
    .meas_reject   (meas_reject),
    .measure_count (measure_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: cycle %0d reached, required finish before limit", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise pps_in at cycle t (pps_rise follows 2 cycles later) and predict the outcome.
  task automatic pulse_at(input int unsigned t);
    int unsigned m;
    logic [63:0] q;
    upd_t u;
    rej_t r;
    wait_until(t);
    if (m_meas) begin
      m = cyc - m_last;
      if (m >= MIN_P && m <= MAX_P) begin
        q = (64'(m) * 64'd4096) / 64'(F_OUT_P);
        m_good = (m_good < LOCK_P) ? m_good + 1 : m_good;
        u.n   = q[43:12];
        u.rem = q[11:0];
        u.at  = cyc + 48;
        u.lck = (m_good >= LOCK_P);
        upd_q.push_back(u);
      end else begin
        r.m  = m;
        r.at = cyc + 3;
        rej_q.push_back(r);
        m_good = 0;
      end
    end
    m_meas = 1'b1;
    m_last = cyc;
    pps_in = 1'b1;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 pps_in = 1'b0;
      end
    join_none
  endtask

  always @(negedge clk) begin
    if (cfg_update) begin
      if (upd_q.size() == 0) check("unexpected_update", 64'(cfg_update), 64'(0));
      else begin
        upd_t u;
        u = upd_q.pop_front();
        check("upd_cycle", 64'(cyc), 64'(u.at));
        check("upd_n_out", 64'(n_out), 64'(u.n));
        check("upd_rem_out", 64'(rem_out), 64'(u.rem));
        check("upd_locked", 64'(locked), 64'(u.lck));
        check("upd_cfg_valid", 64'(cfg_valid), 64'(1));
      end
    end
    if (meas_reject) begin
      if (rej_q.size() == 0) check("unexpected_reject", 64'(meas_reject), 64'(0));
      else begin
        rej_t r;
        r = rej_q.pop_front();
        check("rej_cycle", 64'(cyc), 64'(r.at));
        check("rej_measure_count", 64'(measure_count), 64'(r.m));
      end
    end
  end

  initial begin
    int unsigned tp;
    int unsigned tl;
    int unsigned tr;
    int unsigned t3;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_n_out", 64'(n_out), 64'(N_DEF_P));
    check("rst_rem_out", 64'(rem_out), 64'(0));
    check("rst_measure_count", 64'(measure_count), 64'(0));
    check("rst_flags", 64'({cfg_update, cfg_valid, locked, pps_missing, meas_reject}), 64'(0));

    wait_until(cyc + 3000);
    check("idle_pps_missing", 64'(pps_missing), 64'(0));
    check("idle_n_out", 64'(n_out), 64'(N_DEF_P));
    check("idle_cfg_valid", 64'(cfg_valid), 64'(0));

    // Nominal lock: four edges 1000 apart.
    tp = cyc + 10;
    for (int unsigned i = 0; i < 4; i++) pulse_at(tp + i * 1000);
    tp = tp + 3000;
    wait_until(tp + 60);
    check("nom_locked", 64'(locked), 64'(1));
    check("nom_measure_count", 64'(measure_count), 64'(1000));

    // Fractional periods, back to nominal, then an out-of-range period.
    tp = tp + 1003; pulse_at(tp);
    tp = tp + 999;  pulse_at(tp);
    tp = tp + 1000; pulse_at(tp);
    tp = tp + 300;  pulse_at(tp);
    wait_until(tp + 60);
    check("rej_locked", 64'(locked), 64'(0));
    check("rej_n_out_held", 64'(n_out), 64'(100));
    check("rej_rem_out_held", 64'(rem_out), 64'(0));
    check("rej_measure_kept", 64'(measure_count), 64'(300));
    for (int unsigned i = 0; i < 3; i++) begin
      tp = tp + 1000;
      pulse_at(tp);
    end
    wait_until(tp + 60);
    check("relock_locked", 64'(locked), 64'(1));

    // PPS loss after lock.
    tl = tp;
    wait_until(tl + 2 + TMO_P);
    check("tmo_not_yet", 64'(pps_missing), 64'(0));
    wait_until(tl + 3 + TMO_P);
    check("tmo_pps_missing", 64'(pps_missing), 64'(1));
    check("tmo_locked", 64'(locked), 64'(0));
    check("tmo_n_out_held", 64'(n_out), 64'(100));
    check("tmo_cfg_valid_held", 64'(cfg_valid), 64'(1));
    m_meas = 1'b0;
    m_good = 0;

    tr = tl + 6000;
    pulse_at(tr);
    wait_until(tr + 2);
    check("resume_missing_before", 64'(pps_missing), 64'(1));
    wait_until(tr + 3);
    check("resume_missing_clear", 64'(pps_missing), 64'(0));
    pulse_at(tr + 1000);
    wait_until(tr + 1100);

    // Reset 20 cycles into DIVIDE: division abandoned, outputs at reset values.
    t3 = tr + 2000;
    wait_until(t3);
    pps_in = 1'b1;
    wait_until(t3 + 5);
    pps_in = 1'b0;
    wait_until(t3 + 24);
    reset = 1'b0;
    wait_until(t3 + 27);
    reset = 1'b1;
    m_meas = 1'b0;
    m_good = 0;
    check("mid_rst_n_out", 64'(n_out), 64'(N_DEF_P));
    check("mid_rst_rem_out", 64'(rem_out), 64'(0));
    check("mid_rst_measure_count", 64'(measure_count), 64'(0));
    check("mid_rst_flags", 64'({cfg_valid, locked, pps_missing}), 64'(0));
    wait_until(t3 + 100);
    check("mid_rst_no_update", 64'(cfg_valid), 64'(0));

    // FSM back in IDLE: first edge only arms, second edge yields an update.
    pulse_at(t3 + 200);
    pulse_at(t3 + 1200);
    wait_until(t3 + 1300);
    check("post_rst_cfg_valid", 64'(cfg_valid), 64'(1));
    check("post_rst_measure_count", 64'(measure_count), 64'(1000));

    check("sb_upd_drained", 64'(upd_q.size()), 64'(0));
    check("sb_rej_drained", 64'(rej_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
